memory_arbiter: RTL
===================

# memory_arbiter

Two-into-one arbiter that lets the core's instruction bus and data bus share a single external memory port. Requests from both `Memory` masters are forwarded one at a time with round-robin fairness. An in-order tag FIFO routes each response beat back to the requester that issued it. The block sits between the core's two buses and the single memory interface at the top level.

## Interface

**Parameters**
- `WIDTH`, 32: address and data width.
- `DEPTH`, 4: maximum outstanding requests (tag FIFO depth). Power of two, ≥2.

**Ports**
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_m_address`, `i_m_data`  in  WIDTH  instruction request address, write data.
- `i_m_write`  in  1  instruction request is a write.
- `i_m_valid`  in  1  instruction request valid.
- `i_m_ready`  out  1  instruction request accepted.
- `i_s_data`  out  WIDTH  instruction response data.
- `i_s_valid`  out  1  instruction response valid.
- `i_s_ready`  in  1  instruction response accepted.
- `d_m_*`, `d_s_*`: identical set for the data requester.
- `mem_m_address`, `mem_m_data`  out  WIDTH  forwarded request.
- `mem_m_write`  out  1  forwarded write flag.
- `mem_m_valid`  out  1  forwarded request valid.
- `mem_m_ready`  in  1  memory accepts request.
- `mem_s_data`  in  WIDTH  memory response data.
- `mem_s_valid`  in  1  memory response valid.
- `mem_s_ready`  out  1  response accepted.

## Operation

- **Handshakes:** a transfer occurs on any channel when valid && ready on a rising edge. Every accepted request, read or write, yields exactly one response beat from memory, in request order.
- **Arbiter FSM:** two states, IDLE and HOLD, plus registers `owner` (I/D) and `last`.
  - IDLE: if exactly one requester is valid, grant it. If both are valid, grant the one that is not `last`.
  - The granted request drives `mem_m_*` combinationally. `mem_m_valid` = granted valid && !full.
  - Granted `x_m_ready` = `mem_m_ready` && !full. The other requester's ready is 0.
  - IDLE to HOLD when the granted request is presented but not accepted. `owner` records the grantee.
  - HOLD keeps the grant on `owner` regardless of the other requester, so the forwarded request stays stable. HOLD returns to IDLE on acceptance.
  - On every acceptance: `last` ← grantee and the tag is pushed into the FIFO.
- **Response routing:** FIFO head selects the destination port.
  - `mem_s_data` fans out to both `x_s_data`.
  - Only the head port sees `x_s_valid` = `mem_s_valid`.
  - `mem_s_ready` = head port's `x_s_ready`, and 0 when the FIFO is empty.
  - Pop on a response handshake.
- **Boundaries:**
  - Full (count == DEPTH) blocks new acceptance even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full leave the count unchanged.
  - Empty FIFO: the response is never accepted and no `x_s_valid` is raised.
  - Count width is clog2(DEPTH+1). FIFO pointers wrap modulo DEPTH.

## Timing

- Request and response paths are combinational, adding zero cycles of latency. Grant, tag and count update at the edge of the handshake.
- **Reset (reset == 0, asynchronous):**
  - FSM state IDLE; `last` = D, so I wins the first tie.
  - FIFO count 0, pointers 0.
  - Outputs: `mem_m_valid`, `mem_s_ready`, all `x_m_ready` and `x_s_valid` are 0. Data and address outputs are don't-care.
- **Reset mid-operation:** outstanding tags are discarded. Responses arriving after release are refused (`mem_s_ready` = 0). The system resets memory alongside.
- **Throughput:** one request per cycle. Back-to-back grants alternate when both requesters are continuously valid.

## Structure

- Package `memory_pkg`:
  - `typedef enum logic {PORT_I, PORT_D} port_t`
  - `typedef enum logic {IDLE, HOLD} arb_state_t`
- Sub-module `tag_fifo`:
  - Parameterised DEPTH, 1-bit `port_t` entries.
  - Ports: push, pop, head, full, empty; asynchronous active-low reset.
- Top level `memory_arbiter`: arbiter FSM plus muxing.

## Test plan

1. **Single read.** I read to 0x100 with `mem_m_ready` = 1 → `mem_m_address` = 0x100 the same cycle, `i_m_ready` = 1. Memory returns 0xDEADBEEF → `i_s_valid` = 1, `i_s_data` = 0xDEADBEEF, `d_s_valid` = 0.
2. **Tie after reset.** I (0x10) and D (0x20) are valid the same cycle → 0x10 is forwarded first, 0x20 next cycle. Responses 0xA then 0xB arrive on the I then D ports respectively.
3. **Stall lock.** D is granted and `mem_m_ready` = 0 for 3 cycles while I is valid → grant stays D, `mem_m_address` stable, `i_m_ready` = 0. I is accepted the cycle after D.
4. **Full.** DEPTH = 4 with 4 requests accepted and no responses → 5th request sees `x_m_ready` = 0 and `mem_m_valid` = 0. After one response pop, it is accepted the following cycle.
5. **Response backpressure.** Head tag D, `d_s_ready` = 0, `mem_s_valid` = 1 → `mem_s_ready` = 0, count unchanged, `i_s_valid` = 0.
6. **Reset mid-operation.** 2 outstanding, then reset pulsed low → all valids and readies 0 immediately. After release, `mem_s_valid` = 1 gives `mem_s_ready` = 0 and no `x_s_valid`.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg: port tags and arbiter states shared by the memory arbiter and its tag FIFO
package memory_pkg;
  typedef enum logic {PORT_I, PORT_D} port_t;
  typedef enum logic {IDLE, HOLD} arb_state_t;
endpackage

// File: rtl/memory_arbiter_tag_fifo.sv
// tag_fifo: in-order FIFO of requester tags (push/push_tag in, pop in, head/full/empty out, async active-low reset)
module tag_fifo
  import memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  port_t push_tag,
  input  logic  pop,
  output port_t head,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  port_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= push_tag;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin I/D request arbiter onto one memory port (i_m_*/d_m_* requests, mem_m_* forward, mem_s_* responses routed to i_s_*/d_s_* by tag FIFO)
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_m_address,
  input  logic [WIDTH-1:0] i_m_data,
  input  logic             i_m_write,
  input  logic             i_m_valid,
  output logic             i_m_ready,
  output logic [WIDTH-1:0] i_s_data,
  output logic             i_s_valid,
  input  logic             i_s_ready,
  input  logic [WIDTH-1:0] d_m_address,
  input  logic [WIDTH-1:0] d_m_data,
  input  logic             d_m_write,
  input  logic             d_m_valid,
  output logic             d_m_ready,
  output logic [WIDTH-1:0] d_s_data,
  output logic             d_s_valid,
  input  logic             d_s_ready,
  output logic [WIDTH-1:0] mem_m_address,
  output logic [WIDTH-1:0] mem_m_data,
  output logic             mem_m_write,
  output logic             mem_m_valid,
  input  logic             mem_m_ready,
  input  logic [WIDTH-1:0] mem_s_data,
  input  logic             mem_s_valid,
  output logic             mem_s_ready
);
  arb_state_t state;
  port_t owner, last, grant, head;
  logic full, empty, g_valid, accept, pop, sel_i;
  // HOLD pins the grant so a stalled request stays stable; otherwise ties go to the port not served last
  always_comb grant = state == HOLD ? owner :
                      (i_m_valid && d_m_valid) ? (last == PORT_I ? PORT_D : PORT_I) :
                      i_m_valid ? PORT_I : PORT_D;
  assign sel_i = grant == PORT_I;
  assign g_valid = sel_i ? i_m_valid : d_m_valid;
  // full is 0 while reset holds the FIFO empty, so reset gates the request side explicitly
  assign mem_m_valid = reset && g_valid && !full;
  assign i_m_ready = reset && sel_i && mem_m_ready && !full;
  assign d_m_ready = reset && !sel_i && mem_m_ready && !full;
  assign mem_m_address = sel_i ? i_m_address : d_m_address;
  assign mem_m_data = sel_i ? i_m_data : d_m_data;
  assign mem_m_write = sel_i ? i_m_write : d_m_write;
  assign accept = mem_m_valid && mem_m_ready;
  assign i_s_data = mem_s_data;
  assign d_s_data = mem_s_data;
  assign i_s_valid = !empty && head == PORT_I && mem_s_valid;
  assign d_s_valid = !empty && head == PORT_D && mem_s_valid;
  assign mem_s_ready = !empty && (head == PORT_I ? i_s_ready : d_s_ready);
  assign pop = mem_s_valid && mem_s_ready;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= PORT_I;
      last <= PORT_D;
    end else begin
      state <= accept ? IDLE : g_valid ? HOLD : state;
      owner <= grant;
      if (accept) last <= grant;
    end
  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clock(clock),
    .reset(reset),
    .push(accept),
    .push_tag(grant),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule
